fifo_mst_dpath_gen2: RTL and testbench

Parametrised FT600/FT601 FIFO-master datapath for 16- or 32-bit bus builds. TX side registers outgoing bus data/BE, with command-phase insertion. RX side samples bus data, BE and status on fifoClk flops rather than latches, and buffers received beats in a small skid FIFO with a valid/ready handshake, so the master FSM tolerates downstream stalls. It sits between the master FSM/channel arbiter and the FT60x pad ring.

---
 rtl/fifo_mst_dpath_gen2.sv | 173 +++++++++++++++++
 tb/tb_fifo_mst_dpath_gen2.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mst_dpath_gen2.sv
// fifo_mst_dpath_gen2
// FT600/FT601 FIFO-master datapath, 16- or 32-bit bus builds.
// Sits between the master FSM / channel arbiter and the FT60x pad ring.
//
// TX:  registers outgoing bus data/BE. When snd_cmd is high, the command
//      phase is inserted: BE carries bus_cmd and data carries the
//      zero-extended channel number.
// RX:  registers RXF_N/TXE_N, samples bus data/BE into a capture stage, and
//      pushes valid beats into a small show-ahead skid FIFO with a
//      valid/ready handshake toward the consumer.
//
// Ports
//   fifoClk, fifoRstn        bus clock, async active-low reset
//   tc_data, tc_be           bus data/BE from pads
//   tc_rxf_n, tc_txe_n       bus status from pads
//   snd_cmd, bus_cmd, ep_num command-phase controls from the master FSM
//   tx_data, tx_be           write-data beat
//   rx_cap                   FSM is in a read data phase
//   rx_flush                 synchronous clear of the RX path
//   rx_ready                 consumer accepts the head beat
//   tp_data, tp_be           registered bus data/BE to pads
//   rx_rxf_n, rx_txe_n       registered bus status
//   rx_valid, rx_data, rx_be skid FIFO head
//   rx_cnt                   skid FIFO occupancy (0..RX_DEPTH)
//   rx_afull                 almost full; FSM must stop reading
//   rx_ovf                   sticky overflow (cleared by rx_flush or reset)
module fifo_mst_dpath_gen2 #(
  parameter int WIDTH_DATA         = 32,
  parameter int CNT_BE             = WIDTH_DATA / 8,
  parameter int CNT_CODE_NUM_CHNLS = 2,
  parameter int RX_DEPTH           = 4,
  parameter int RX_AFULL           = 2
) (
  input  logic                            fifoClk,
  input  logic                            fifoRstn,
  input  logic [WIDTH_DATA-1:0]           tc_data,
  input  logic [CNT_BE-1:0]               tc_be,
  input  logic                            tc_rxf_n,
  input  logic                            tc_txe_n,
  input  logic                            snd_cmd,
  input  logic [CNT_BE-1:0]               bus_cmd,
  input  logic [CNT_CODE_NUM_CHNLS:0]     ep_num,
  input  logic [WIDTH_DATA-1:0]           tx_data,
  input  logic [CNT_BE-1:0]               tx_be,
  input  logic                            rx_cap,
  input  logic                            rx_flush,
  input  logic                            rx_ready,
  output logic [WIDTH_DATA-1:0]           tp_data,
  output logic [CNT_BE-1:0]               tp_be,
  output logic                            rx_rxf_n,
  output logic                            rx_txe_n,
  output logic                            rx_valid,
  output logic [WIDTH_DATA-1:0]           rx_data,
  output logic [CNT_BE-1:0]               rx_be,
  output logic [$clog2(RX_DEPTH):0]       rx_cnt,
  output logic                            rx_afull,
  output logic                            rx_ovf
);

  localparam int AW  = $clog2(RX_DEPTH);
  localparam int CW  = AW + 1;
  localparam int EPW = CNT_CODE_NUM_CHNLS + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RX_DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(RX_AFULL);

  // TX path and status
  logic [WIDTH_DATA-1:0] tp_data_q, tp_data_d;
  logic [CNT_BE-1:0]     tp_be_q, tp_be_d;
  logic                  rxf_n_q, txe_n_q;

  // capture stage
  logic                  cap_vld_q, cap_vld_d;
  logic [WIDTH_DATA-1:0] cap_data_q;
  logic [CNT_BE-1:0]     cap_be_q;

  // skid FIFO
  logic [WIDTH_DATA-1:0] mem_data [RX_DEPTH];
  logic [CNT_BE-1:0]     mem_be   [RX_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  afull_q, afull_d;
  logic                  ovf_q, ovf_d;

  logic full, pop, push_ok, wr_en;

  always_comb begin
    tp_data_d = tx_data;
    tp_be_d   = tx_be;
    if (snd_cmd) begin
      tp_data_d = {{(WIDTH_DATA-EPW){1'b0}}, ep_num};
      tp_be_d   = bus_cmd;
    end
  end

  assign full = (cnt_q == DEPTH_C);
  assign pop  = (cnt_q != '0) & rx_ready;
  // A push at full is still accepted when the head leaves on the same edge.
  assign push_ok = cap_vld_q & (~full | pop);
  assign wr_en   = push_ok & ~rx_flush;

  always_comb begin
    cap_vld_d = rx_cap & ~tc_rxf_n & (|tc_be);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q | (cap_vld_q & full & ~pop);
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (rx_flush) begin
      cap_vld_d = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
    end
    afull_d = ((DEPTH_C - cnt_d) <= AFULL_C);
    if (rx_flush) afull_d = 1'b0;
  end

  always_ff @(posedge fifoClk or negedge fifoRstn) begin
    if (!fifoRstn) begin
      tp_data_q <= '1;
      tp_be_q   <= '1;
      rxf_n_q   <= 1'b1;
      txe_n_q   <= 1'b1;
      cap_vld_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      tp_data_q <= tp_data_d;
      tp_be_q   <= tp_be_d;
      rxf_n_q   <= tc_rxf_n;
      txe_n_q   <= tc_txe_n;
      cap_vld_q <= cap_vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
    end
  end

  // Payload registers carry no reset; they are qualified by cap_vld / rx_valid.
  always_ff @(posedge fifoClk) begin
    cap_data_q <= tc_data;
    cap_be_q   <= tc_be;
    if (wr_en) begin
      mem_data[wr_ptr_q] <= cap_data_q;
      mem_be[wr_ptr_q]   <= cap_be_q;
    end
  end

  assign tp_data  = tp_data_q;
  assign tp_be    = tp_be_q;
  assign rx_rxf_n = rxf_n_q;
  assign rx_txe_n = txe_n_q;
  assign rx_valid = (cnt_q != '0);
  assign rx_data  = mem_data[rd_ptr_q];
  assign rx_be    = mem_be[rd_ptr_q];
  assign rx_cnt   = cnt_q;
  assign rx_afull = afull_q;
  assign rx_ovf   = ovf_q;

endmodule

// File: tb/tb_fifo_mst_dpath_gen2.sv
module tb_fifo_mst_dpath_gen2;

  logic        fifoClk = 1'b0;
  logic        fifoRstn;
  logic [31:0] tc_data;
  logic [3:0]  tc_be;
  logic        tc_rxf_n, tc_txe_n;
  logic        snd_cmd;
  logic [3:0]  bus_cmd;
  logic [2:0]  ep_num;
  logic [31:0] tx_data;
  logic [3:0]  tx_be;
  logic        rx_cap, rx_flush, rx_ready;
  logic [31:0] tp_data;
  logic [3:0]  tp_be;
  logic        rx_rxf_n, rx_txe_n, rx_valid;
  logic [31:0] rx_data;
  logic [3:0]  rx_be;
  logic [2:0]  rx_cnt;
  logic        rx_afull, rx_ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 fifoClk = ~fifoClk;

  fifo_mst_dpath_gen2 dut (
    .fifoClk  (fifoClk),
    .fifoRstn (fifoRstn),
    .tc_data  (tc_data),
    .tc_be    (tc_be),
    .tc_rxf_n (tc_rxf_n),
    .tc_txe_n (tc_txe_n),
    .snd_cmd  (snd_cmd),
    .bus_cmd  (bus_cmd),
    .ep_num   (ep_num),
    .tx_data  (tx_data),
    .tx_be    (tx_be),
    .rx_cap   (rx_cap),
    .rx_flush (rx_flush),
    .rx_ready (rx_ready),
    .tp_data  (tp_data),
    .tp_be    (tp_be),
    .rx_rxf_n (rx_rxf_n),
    .rx_txe_n (rx_txe_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_be    (rx_be),
    .rx_cnt   (rx_cnt),
    .rx_afull (rx_afull),
    .rx_ovf   (rx_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge fifoClk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] be);
    tc_data  = d;
    tc_be    = be;
    rx_cap   = 1'b1;
    tc_rxf_n = 1'b0;
    step();
  endtask

  task automatic bus_idle();
    rx_cap   = 1'b0;
    tc_rxf_n = 1'b1;
    tc_be    = 4'h0;
    tc_data  = '0;
  endtask

  initial begin
    fifoRstn = 1'b0;
    snd_cmd  = 1'b1;
    bus_cmd  = 4'h1;
    ep_num   = 3'd3;
    tx_data  = '0;
    tx_be    = '0;
    tc_txe_n = 1'b1;
    rx_flush = 1'b0;
    rx_ready = 1'b0;
    bus_idle();
    step();
    step();

    // reset state
    chk("rst_tp_data", tp_data, 32'hFFFF_FFFF);
    chk("rst_tp_be", tp_be, 4'hF);
    chk("rst_rxf_n", rx_rxf_n, 1'b1);
    chk("rst_txe_n", rx_txe_n, 1'b1);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_cnt", rx_cnt, 3'd0);
    chk("rst_afull", rx_afull, 1'b0);
    chk("rst_ovf", rx_ovf, 1'b0);

    // TX command phase then data phase
    fifoRstn = 1'b1;
    tc_txe_n = 1'b0;
    step();
    chk("cmd_tp_be", tp_be, 4'h1);
    chk("cmd_tp_data", tp_data, 32'h0000_0003);
    chk("stat_txe_n", rx_txe_n, 1'b0);
    chk("stat_rxf_n", rx_rxf_n, 1'b1);
    snd_cmd = 1'b0;
    tx_data = 32'hA5A5_1234;
    tx_be   = 4'hF;
    step();
    chk("tx_tp_data", tp_data, 32'hA5A5_1234);
    chk("tx_tp_be", tp_be, 4'hF);
    snd_cmd = 1'b1;
    bus_cmd = 4'h2;
    ep_num  = 3'd7;
    tx_data = 32'hFFFF_FFFF;
    step();
    chk("cmd2_tp_data", tp_data, 32'h0000_0007);
    chk("cmd2_tp_be", tp_be, 4'h2);
    snd_cmd = 1'b0;

    // streaming with consumer always ready
    rx_ready = 1'b1;
    beat(32'h11, 4'hF);
    chk("str_valid_e1", rx_valid, 1'b0);
    chk("str_rxf_n", rx_rxf_n, 1'b0);
    beat(32'h22, 4'hF);
    chk("str_valid_e2", rx_valid, 1'b1);
    chk("str_d11", rx_data, 32'h11);
    chk("str_cnt_e2", rx_cnt, 3'd1);
    beat(32'h33, 4'hF);
    chk("str_d22", rx_data, 32'h22);
    chk("str_cnt_e3", rx_cnt, 3'd1);
    bus_idle();
    step();
    chk("str_d33", rx_data, 32'h33);
    chk("str_cnt_e4", rx_cnt, 3'd1);
    step();
    chk("str_valid_end", rx_valid, 1'b0);

    // stalled consumer: fill, afull, overflow, drain
    rx_ready = 1'b0;
    beat(32'h1, 4'hF);
    beat(32'h2, 4'hF);
    chk("ovf_cnt1", rx_cnt, 3'd1);
    chk("ovf_afull_c1", rx_afull, 1'b0);
    beat(32'h3, 4'hF);
    chk("ovf_cnt2", rx_cnt, 3'd2);
    chk("ovf_afull_c2", rx_afull, 1'b1);
    beat(32'h4, 4'hF);
    chk("ovf_cnt3", rx_cnt, 3'd3);
    beat(32'h5, 4'hF);
    chk("ovf_cnt4", rx_cnt, 3'd4);
    chk("ovf_pre", rx_ovf, 1'b0);
    beat(32'h6, 4'hF);
    chk("ovf_set", rx_ovf, 1'b1);
    chk("ovf_cnt_full", rx_cnt, 3'd4);
    bus_idle();
    step();
    chk("ovf_cnt_drop6", rx_cnt, 3'd4);
    rx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_drain_valid", rx_valid, 1'b1);
      chk("ovf_drain_data", rx_data, 32'(i));
      step();
    end
    chk("ovf_drain_empty", rx_valid, 1'b0);
    chk("ovf_sticky", rx_ovf, 1'b1);
    chk("ovf_afull_clr", rx_afull, 1'b0);
    rx_flush = 1'b1;
    step();
    rx_flush = 1'b0;
    chk("ovf_flush_clr", rx_ovf, 1'b0);

    // full with simultaneous push and pop, data order through pointer wrap
    rx_ready = 1'b0;
    beat(32'h41, 4'hF);
    beat(32'h42, 4'hF);
    beat(32'h43, 4'hF);
    beat(32'h44, 4'hF);
    beat(32'h45, 4'hF);
    chk("fpp_cnt_full", rx_cnt, 3'd4);
    rx_ready = 1'b1;
    beat(32'h46, 4'hF);
    chk("fpp_cnt_e6", rx_cnt, 3'd4);
    chk("fpp_head_e6", rx_data, 32'h42);
    chk("fpp_no_ovf", rx_ovf, 1'b0);
    beat(32'h47, 4'hF);
    chk("fpp_cnt_e7", rx_cnt, 3'd4);
    bus_idle();
    step();
    chk("fpp_cnt_e8", rx_cnt, 3'd4);
    chk("fpp_head_e8", rx_data, 32'h44);
    step();
    chk("fpp_cnt_e9", rx_cnt, 3'd3);
    for (int i = 5; i <= 7; i++) begin
      chk("fpp_wrap_data", rx_data, 32'h40 + 32'(i));
      step();
    end
    chk("fpp_empty", rx_valid, 1'b0);
    chk("fpp_ovf_end", rx_ovf, 1'b0);

    // zero-BE beat is discarded
    rx_ready = 1'b0;
    beat(32'h51, 4'hF);
    beat(32'h52, 4'h0);
    beat(32'h53, 4'h3);
    chk("zbe_cnt_skip", rx_cnt, 3'd1);
    bus_idle();
    step();
    chk("zbe_cnt2", rx_cnt, 3'd2);
    step();
    chk("zbe_cnt_hold", rx_cnt, 3'd2);
    rx_ready = 1'b1;
    chk("zbe_d51", rx_data, 32'h51);
    step();
    chk("zbe_d53", rx_data, 32'h53);
    chk("zbe_be53", rx_be, 4'h3);
    step();
    chk("zbe_empty", rx_valid, 1'b0);

    // flush at rx_cnt=3 with overflow set
    rx_ready = 1'b0;
    beat(32'h61, 4'hF);
    beat(32'h62, 4'hF);
    beat(32'h63, 4'hF);
    beat(32'h64, 4'hF);
    beat(32'h65, 4'hF);
    bus_idle();
    step();
    chk("fl_ovf_set", rx_ovf, 1'b1);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("fl_cnt3", rx_cnt, 3'd3);
    chk("fl_head62", rx_data, 32'h62);
    chk("fl_afull3", rx_afull, 1'b1);
    rx_flush = 1'b1;
    snd_cmd  = 1'b0;
    tx_data  = 32'hCAFE_0001;
    tx_be    = 4'h5;
    step();
    rx_flush = 1'b0;
    chk("fl_cnt0", rx_cnt, 3'd0);
    chk("fl_valid0", rx_valid, 1'b0);
    chk("fl_ovf0", rx_ovf, 1'b0);
    chk("fl_afull0", rx_afull, 1'b0);
    chk("fl_tx_ok", tp_data, 32'hCAFE_0001);

    // async reset mid-stream
    beat(32'h71, 4'hF);
    beat(32'h72, 4'hF);
    beat(32'h73, 4'hF);
    chk("ar_cnt_pre", rx_cnt, 3'd2);
    #2;
    fifoRstn = 1'b0;
    #1;
    chk("ar_tp_data", tp_data, 32'hFFFF_FFFF);
    chk("ar_tp_be", tp_be, 4'hF);
    chk("ar_rxf_n", rx_rxf_n, 1'b1);
    chk("ar_valid", rx_valid, 1'b0);
    chk("ar_cnt", rx_cnt, 3'd0);
    bus_idle();
    step();
    fifoRstn = 1'b1;
    step();
    step();
    chk("ar_no_partial", rx_valid, 1'b0);
    chk("ar_cnt_after", rx_cnt, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
